// File: rtl/wide_add_sequencer_if.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer_if
// Purpose : operand/result handshake bundle for wide_add_sequencer.
// Signals : in_valid/in_ready/a/b/cin (operand side, plus sub when
//           WIDE_ADD_SUB_EN is defined), out_valid/out_ready/sum/cout
//           (result side), busy (status).
// Modports: master = requester/consumer side, slave = the sequencer.
// Optional: WIDE_ADD_SUB_EN adds the 1-bit 'sub' operand-side request.
// ---------------------------------------------------------------------------
interface wide_add_sequencer_if #(
    parameter int N = 32,
    parameter int K = 4
);
    localparam int W = N * K;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
`ifdef WIDE_ADD_SUB_EN
    logic         sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

`ifdef WIDE_ADD_SUB_EN
    modport master (output in_valid, a, b, cin, sub, out_ready,
                    input  in_ready, out_valid, sum, cout, busy);
    modport slave  (input  in_valid, a, b, cin, sub, out_ready,
                    output in_ready, out_valid, sum, cout, busy);
`else
    modport master (output in_valid, a, b, cin, out_ready,
                    input  in_ready, out_valid, sum, cout, busy);
    modport slave  (input  in_valid, a, b, cin, out_ready,
                    output in_ready, out_valid, sum, cout, busy);
`endif
endinterface

// File: rtl/wide_add_sequencer.sv
// ---------------------------------------------------------------------------
// wide_add_sequencer
// Purpose : adds two W = N*K bit operands with one N-bit adder slice reused
//           over K cycles, least significant slice first. The slice carry is
//           registered between cycles. One operation in flight at a time.
// Ports   : i_clk  - clock, rising edge
//           i_rst  - synchronous reset, active-high
//           bus    - wide_add_sequencer_if.slave (operand/result handshakes,
//                    busy status)
// Optional: WIDE_ADD_SUB_EN - adds 'sub'; when set at accept, b is inverted
//           and the initial carry forced to 1 so the result is a - b.
// Timing  : out_valid rises K cycles after the accept edge; all outputs are
//           driven straight from registers.
// ---------------------------------------------------------------------------
module wide_add_sequencer #(
    parameter int N = 32,
    parameter int K = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    wide_add_sequencer_if.slave   bus
);
    localparam int W  = N * K;
    localparam int IW = (K > 1) ? $clog2(K) : 1;

    localparam logic [IW-1:0] IDX_LAST = IW'(K - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [IW-1:0] r_idx;
    logic          r_carry;
    logic [W-1:0]  r_a;
    logic [W-1:0]  r_b;
    logic [W-1:0]  r_sum;
    logic          r_cout;
    logic          r_in_ready;
    logic          r_out_valid;
    logic          r_busy;

    logic [N-1:0]  w_a_slice;
    logic [N-1:0]  w_b_slice;
    logic [N:0]    w_slice_res;
    logic          w_b_invert;
    logic          w_carry_init;

    // Selects operand slice idx with an AND-OR mux so no latch or priority chain is built.
    always_comb begin
        w_a_slice = {N{1'b0}};
        w_b_slice = {N{1'b0}};
        for (int k = 0; k < K; k++) begin
            w_a_slice = w_a_slice | (r_a[k*N +: N] & {N{r_idx == IW'(k)}});
            w_b_slice = w_b_slice | (r_b[k*N +: N] & {N{r_idx == IW'(k)}});
        end
    end

    // The single N-bit slice adder; bit N is the slice carry-out.
    always_comb begin
        w_slice_res = {1'b0, w_a_slice} + {1'b0, w_b_slice} + {{N{1'b0}}, r_carry};
    end

    // Operand conditioning at accept: subtraction is a + ~b + 1.
    always_comb begin
`ifdef WIDE_ADD_SUB_EN
        w_b_invert   = bus.sub;
        w_carry_init = bus.sub ? 1'b1 : bus.cin;
`else
        w_b_invert   = 1'b0;
        w_carry_init = bus.cin;
`endif
    end

    // Control FSM and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_idx       <= {IW{1'b0}};
            r_carry     <= 1'b0;
            r_a         <= {W{1'b0}};
            r_b         <= {W{1'b0}};
            r_sum       <= {W{1'b0}};
            r_cout      <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid && r_in_ready) begin
                        r_a        <= bus.a;
                        r_b        <= w_b_invert ? ~bus.b : bus.b;
                        r_carry    <= w_carry_init;
                        r_idx      <= {IW{1'b0}};
                        r_state    <= ST_RUN;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end else begin
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // Only the slice being computed is written; the others hold.
                    for (int k = 0; k < K; k++) begin
                        if (r_idx == IW'(k)) begin
                            r_sum[k*N +: N] <= w_slice_res[N-1:0];
                        end
                    end
                    r_carry <= w_slice_res[N];
                    if (r_idx == IDX_LAST) begin
                        r_cout      <= w_slice_res[N];
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle.
                    r_state     <= ST_IDLE;
                    r_idx       <= {IW{1'b0}};
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.sum       = r_sum;
    assign bus.cout      = r_cout;
    assign bus.busy      = r_busy;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Scoreboard bench for wide_add_sequencer with N=8, K=4 (W=32).
module tb_wide_add_sequencer;
    localparam int N = 8;
    localparam int K = 4;
    localparam int W = N * K;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    int   cyc;

    exp_t sb_q[$];
    int   lat_q[$];
    int   acc_log[$];
    logic prev_valid;

    wide_add_sequencer_if #(.N(N), .K(K)) bus ();

    wide_add_sequencer #(.N(N), .K(K)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        n_tests = n_tests + 1;
        if (act !== req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: latency, accept log and result scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            lat_q.delete();
            prev_valid = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                lat_q.push_back(cyc + 1);
                acc_log.push_back(cyc + 1);
            end
            if (bus.out_valid && !prev_valid) begin
                if (lat_q.size() == 0) begin
                    check("unexpected_out_valid", 32'd1, 32'd0);
                end else begin
                    check("latency", 32'(cyc - lat_q.pop_front()), 32'd4);
                end
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_result", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("sum", bus.sum, e.sum);
                    check("cout", {31'd0, bus.cout}, {31'd0, e.cout});
                end
            end
            prev_valid = bus.out_valid;
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input logic s, input logic push, input logic [W-1:0] es, input logic ec);
        exp_t e;
        bit   ok;
        e.sum  = es;
        e.cout = ec;
        if (push) sb_q.push_back(e);
        bus.a        = a;
        bus.b        = b;
        bus.cin      = c;
`ifdef WIDE_ADD_SUB_EN
        bus.sub      = s;
`else
        if (s) $display("note: sub request ignored in add-only build");
`endif
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            check("accept_timeout", 32'd1, 32'd0);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            check("drain_timeout", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        cyc          = 0;
        prev_valid   = 1'b0;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.a        = 32'd0;
        bus.b        = 32'd0;
        bus.cin      = 1'b0;
`ifdef WIDE_ADD_SUB_EN
        bus.sub      = 1'b0;
`endif
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        check("rst_sum",       bus.sum,                32'd0);
        check("rst_cout",      {31'd0, bus.cout},      32'd0);
        @(posedge clk);
        #1;

        // 1: basic add
        send(32'd1209, 32'd4565, 1'b0, 1'b0, 1'b1, 32'h0000_168E, 1'b0);
        bus.in_valid = 1'b0;
        drain();

        // 2: full ripple and carry-in only
        send(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
        bus.in_valid = 1'b0;
        drain();
        send(32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 32'h0000_0001, 1'b0);
        bus.in_valid = 1'b0;
        drain();
        send(32'h80FF_00FF, 32'h8001_FF01, 1'b0, 1'b0, 1'b1, 32'h0101_0000, 1'b1);
        bus.in_valid = 1'b0;
        drain();

        // 3: back-pressure in DONE for 3 cycles
        bus.out_ready = 1'b0;
        send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'h2345_6789, 1'b0);
        bus.in_valid = 1'b0;
        for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("hold_out_valid", {31'd0, bus.out_valid}, 32'd1);
            check("hold_in_ready",  {31'd0, bus.in_ready},  32'd0);
            check("hold_busy",      {31'd0, bus.busy},      32'd1);
            check("hold_sum",       bus.sum,                32'h2345_6789);
            check("hold_cout",      {31'd0, bus.cout},      32'd0);
            if (i < 2) @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("post_hold_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("post_hold_out_valid", {31'd0, bus.out_valid}, 32'd0);
        drain();

        // 4: reset during the 2nd RUN cycle aborts the op
        send(32'd1, 32'd2, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_in_ready",  {31'd0, bus.in_ready},  32'd1);
        check("abort_out_valid", {31'd0, bus.out_valid}, 32'd0);
        check("abort_busy",      {31'd0, bus.busy},      32'd0);
        repeat (6) @(negedge clk);
        check("abort_no_valid",  {31'd0, bus.out_valid}, 32'd0);
        @(posedge clk);
        #1;
        send(32'd7, 32'd8, 1'b0, 1'b0, 1'b1, 32'd15, 1'b0);
        bus.in_valid = 1'b0;
        drain();

        // 5: back-to-back ops with operands disturbed during RUN
        acc_log.delete();
        send(32'd100, 32'd200, 1'b0, 1'b0, 1'b1, 32'd300, 1'b0);
        bus.a = 32'hA5A5_A5A5;
        bus.b = 32'h5A5A_5A5A;
        bus.cin = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        send(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, 1'b0, 1'b1, 32'hEFBE_D000, 1'b0);
        bus.a = 32'hFFFF_FFFF;
        bus.b = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        #1;
        send(32'hF000_0000, 32'h2000_0000, 1'b1, 1'b0, 1'b1, 32'h1000_0001, 1'b1);
        bus.in_valid = 1'b0;
        drain();
        check("accept_count", 32'(acc_log.size()), 32'd3);
        if (acc_log.size() == 3) begin
            check("interval_1", 32'(acc_log[1] - acc_log[0]), 32'd6);
            check("interval_2", 32'(acc_log[2] - acc_log[1]), 32'd6);
        end

`ifdef WIDE_ADD_SUB_EN
        // 6: subtraction
        send(32'd5, 32'd7, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0);
        bus.in_valid = 1'b0;
        drain();
        send(32'd7, 32'd5, 1'b0, 1'b1, 1'b1, 32'd2, 1'b1);
        bus.in_valid = 1'b0;
        drain();
        send(32'd7, 32'd5, 1'b0, 1'b0, 1'b1, 32'd12, 1'b0);
        bus.in_valid = 1'b0;
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
